// File: rtl/ws_sched_pkg.sv
// Shared types and constants for the WS2811 frame scheduler.
// Optional build macro WS_SCHED_PRIO0_EN is consumed by ws_rr_arbiter.
package ws_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam int N_REQ            = 3;
  localparam int COLOR_W          = 24;
  localparam int IDX_W            = 4;
  localparam int N_LEDS_DEF       = 11;
  localparam int LATCH_CYCLES_DEF = 2500;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ws_rr_arbiter.sv
// Combinational frame arbiter: round-robin from the slot after the last owner.
// Build macro WS_SCHED_PRIO0_EN gives source 0 strict priority over 1 and 2.
module ws_rr_arbiter
  import ws_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       last_i,
  output logic [N_REQ-1:0] winner_o
);

`ifdef WS_SCHED_PRIO0_EN
  always_comb begin
    winner_o = '0;
    if (req_i[0]) begin
      winner_o = 3'b001;
    end else if (req_i[1] && (!req_i[2] || last_i != 2'd1)) begin
      winner_o = 3'b010;
    end else if (req_i[2]) begin
      winner_o = 3'b100;
    end
  end
`else
  always_comb begin
    logic found;
    winner_o = '0;
    found    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      automatic int c = (int'(last_i) + k) % N_REQ;
      if (!found && req_i[c]) begin
        winner_o[c] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ws2811_frame_scheduler.sv
// Arbitrates whole frames between three pixel sources onto one WS2811 serializer.
// Build macro WS_SCHED_PRIO0_EN (see ws_rr_arbiter) selects strict priority for source 0.
module ws2811_frame_scheduler
  import ws_sched_pkg::*;
#(
  parameter int N_LEDS       = N_LEDS_DEF,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [2:0]         req_i,
  input  logic [23:0]        pixel_data0_i,
  input  logic [23:0]        pixel_data1_i,
  input  logic [23:0]        pixel_data2_i,
  input  logic               tx_ready_i,
  output logic [2:0]         grant_o,
  output logic [3:0]         pixel_idx_o,
  output logic               tx_valid_o,
  output logic [23:0]        tx_data_o,
  output logic [2:0]         frame_done_o,
  output logic               busy_o
);

  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [N_REQ-1:0]   winner;

  ws_rr_arbiter u_arb (
    .req_i    (req_i),
    .last_i   (ptr_q),
    .winner_o (winner)
  );

  // Pointer reset to 2 so source 0 is first in line after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && (req_i != '0)) begin
          grant_d = winner;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          if (idx_q == IDX_W'(N_LEDS - 1)) begin
            cnt_d   = CNT_W'(LATCH_CYCLES - 1);
            state_d = ST_LATCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (cnt_q == '0) begin
          ptr_d   = onehot_to_idx(grant_q);
          grant_d = '0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data_o = '0;
    case (grant_q)
      3'b001:  tx_data_o = pixel_data0_i;
      3'b010:  tx_data_o = pixel_data1_i;
      3'b100:  tx_data_o = pixel_data2_i;
      default: tx_data_o = '0;
    endcase
  end

  assign grant_o      = grant_q;
  assign pixel_idx_o  = idx_q;
  assign tx_valid_o   = (state_q == ST_SEND);
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = ((state_q == ST_LATCH) && (cnt_q == '0)) ? grant_q : '0;

endmodule
